// File: rtl/piso_shift_param.sv
// Parametrised parallel-in/serial-out shifter with load/ready handshake,
// clock-enable pacing, selectable idle level and a one-cycle Done pulse per frame.
module piso_shift_param #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic [WIDTH-1:0] Parallel_In,
  input  logic             Shift_En,
  output logic             Ready,
  output logic             Busy,
  output logic             Serial_Out,
  output logic             Done
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             serial_q, serial_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] sregAdvanced;
  logic             firstBit;
  logic             nextBit;

  // The bit leaving the output end wraps round to the far end; it is never
  // sent again because the counter ends the frame first.
  if (MSB_FIRST) begin : gen_msb_first
    assign sregAdvanced = {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]};
    assign firstBit     = Parallel_In[WIDTH-1];
    assign nextBit      = sreg_q[WIDTH-2];
  end else begin : gen_lsb_first
    assign sregAdvanced = {sreg_q[0], sreg_q[WIDTH-1:1]};
    assign firstBit     = Parallel_In[0];
    assign nextBit      = sreg_q[1];
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sreg_q   <= '0;
      serial_q <= IDLE_LEVEL;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sreg_d   = sreg_q;
    serial_d = serial_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        serial_d = IDLE_LEVEL;
        if (load) begin
          sreg_d   = Parallel_In;
          cnt_d    = '0;
          serial_d = firstBit;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (Shift_En) begin
          if (cnt_q == LAST_BIT) begin
            state_d  = IDLE;
            cnt_d    = '0;
            serial_d = IDLE_LEVEL;
            done_d   = 1'b1;
          end else begin
            sreg_d   = sregAdvanced;
            cnt_d    = cnt_q + 1'b1;
            serial_d = nextBit;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign Ready      = (state_q == IDLE);
  assign Busy       = (state_q == SHIFT);
  assign Serial_Out = serial_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_piso_shift_param.sv
// Self-checking bench for piso_shift_param: two configurations (4-bit MSB-first
// idle 0, 8-bit LSB-first idle 1) against a word/bit-index reference model.
module tb_piso_shift_param;

  logic        clk = 1'b0;
  logic        clear_n;
  logic [1:0]  loadS;
  logic [1:0]  shiftEnS;
  logic [31:0] pinS [2];
  logic [1:0]  readyS, busyS, serialS, doneS;
  bit          checkEn = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int W   = (g == 0) ? 4 : 8;
    localparam bit MSB = (g == 0);
    localparam bit IDL = (g == 1);

    logic [W-1:0] pinW;
    assign pinW = pinS[g][W-1:0];

    piso_shift_param #(
      .WIDTH(W),
      .MSB_FIRST(MSB),
      .IDLE_LEVEL(IDL)
    ) dut (
      .clk(clk),
      .clear_n(clear_n),
      .load(loadS[g]),
      .Parallel_In(pinW),
      .Shift_En(shiftEnS[g]),
      .Ready(readyS[g]),
      .Busy(busyS[g]),
      .Serial_Out(serialS[g]),
      .Done(doneS[g])
    );

    // Reference: the frame is a stored word plus the index of the bit on the line.
    bit          inFlight = 1'b0;
    int          bitIdx   = 0;
    logic [31:0] word     = '0;
    bit          expDone  = 1'b0;

    always @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
        inFlight = 1'b0;
        bitIdx   = 0;
        word     = '0;
        expDone  = 1'b0;
      end else begin
        expDone = 1'b0;
        if (!inFlight) begin
          if (loadS[g]) begin
            inFlight = 1'b1;
            bitIdx   = 0;
            word     = pinS[g];
          end
        end else if (shiftEnS[g]) begin
          if (bitIdx == W - 1) begin
            inFlight = 1'b0;
            expDone  = 1'b1;
          end else begin
            bitIdx++;
          end
        end
      end
    end

    always @(negedge clk) begin
      if (checkEn) begin
        logic expSerial;
        expSerial = inFlight ? (MSB ? word[W-1-bitIdx] : word[bitIdx]) : IDL;
        checkOutput($sformatf("model%0d.serial", g), 32'(serialS[g]), 32'(expSerial));
        checkOutput($sformatf("model%0d.ready", g), 32'(readyS[g]), 32'(!inFlight));
        checkOutput($sformatf("model%0d.busy", g), 32'(busyS[g]), 32'(inFlight));
        checkOutput($sformatf("model%0d.done", g), 32'(doneS[g]), 32'(expDone));
      end
    end
  end

  // Hand-derived sequences from the frame examples.
  int seqMsb   [5]  = '{0, 1, 0, 1, 0};
  int seqLsb   [9]  = '{0, 0, 0, 1, 0, 0, 1, 1, 1};
  int seqB2b   [10] = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0};
  int doneB2b  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int seqPaced [4]  = '{1, 0, 1, 0};
  int seqAfter [5]  = '{0, 0, 1, 1, 0};

  task automatic applyStimulus(input int g, input logic ld, input logic [31:0] pin, input logic en);
    loadS[g]    = ld;
    pinS[g]     = pin;
    shiftEnS[g] = en;
  endtask

  initial begin
    int doneCount;
    int busyCount;

    clear_n = 1'b1;
    applyStimulus(0, 1'b0, '0, 1'b0);
    applyStimulus(1, 1'b0, '0, 1'b0);
    #1 clear_n = 1'b0;
    repeat (3) tick();
    checkOutput("rst.readyA", 32'(readyS[0]), 32'd1);
    checkOutput("rst.busyA", 32'(busyS[0]), 32'd0);
    checkOutput("rst.doneA", 32'(doneS[0]), 32'd0);
    checkOutput("rst.serialA", 32'(serialS[0]), 32'd0);
    checkOutput("rst.serialB", 32'(serialS[1]), 32'd1);
    clear_n = 1'b1;
    checkEn = 1'b1;

    for (int k = 0; k < 4; k++) begin
      shiftEnS[0] = ~shiftEnS[0];
      tick();
      checkOutput("idleEn.serialA", 32'(serialS[0]), 32'd0);
      checkOutput("idleEn.readyA", 32'(readyS[0]), 32'd1);
    end
    shiftEnS[0] = 1'b0;
    tick();

    // MSB-first 4'b0101
    applyStimulus(0, 1'b1, 32'h5, 1'b1);
    doneCount = 0;
    busyCount = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      loadS[0] = 1'b0;
      checkOutput($sformatf("msb.bit%0d", k), 32'(serialS[0]), 32'(seqMsb[k]));
      doneCount += int'(doneS[0]);
      busyCount += int'(busyS[0]);
    end
    checkOutput("msb.doneAtCycle5", 32'(doneS[0]), 32'd1);
    checkOutput("msb.doneCount", 32'(doneCount), 32'd1);
    checkOutput("msb.busyCycles", 32'(busyCount), 32'd4);
    repeat (2) tick();

    // LSB-first 8'hC8 with idle level 1
    applyStimulus(1, 1'b1, 32'hC8, 1'b1);
    for (int k = 0; k < 9; k++) begin
      tick();
      loadS[1] = 1'b0;
      checkOutput($sformatf("lsb.bit%0d", k), 32'(serialS[1]), 32'(seqLsb[k]));
    end
    checkOutput("lsb.done", 32'(doneS[1]), 32'd1);
    applyStimulus(1, 1'b0, '0, 1'b0);
    repeat (2) tick();

    // Back-to-back frames with load held high
    applyStimulus(0, 1'b1, 32'h8, 1'b1);
    doneCount = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) pinS[0] = 32'hC;
      if (k == 8) loadS[0] = 1'b0;
      checkOutput($sformatf("b2b.bit%0d", k), 32'(serialS[0]), 32'(seqB2b[k]));
      checkOutput($sformatf("b2b.done%0d", k), 32'(doneS[0]), 32'(doneB2b[k]));
      doneCount += int'(doneS[0]);
    end
    checkOutput("b2b.doneCount", 32'(doneCount), 32'd2);
    applyStimulus(0, 1'b0, '0, 1'b0);
    repeat (2) tick();

    // Paced shifting: enable one cycle in three
    applyStimulus(0, 1'b1, 32'hA, 1'b0);
    for (int k = 0; k < 13; k++) begin
      tick();
      loadS[0] = 1'b0;
      checkOutput($sformatf("paced.serial%0d", k), 32'(serialS[0]),
                  32'((k < 12) ? seqPaced[k/3] : 0));
      checkOutput($sformatf("paced.done%0d", k), 32'(doneS[0]), 32'(k == 12));
      shiftEnS[0] = ((k % 3) == 2);
    end
    applyStimulus(0, 1'b0, '0, 1'b0);
    repeat (2) tick();

    // Asynchronous reset during the second bit of 4'hF
    applyStimulus(0, 1'b1, 32'hF, 1'b1);
    tick();
    loadS[0] = 1'b0;
    tick();
    checkOutput("rstMid.bit1", 32'(serialS[0]), 32'd1);
    #2 clear_n = 1'b0;
    #1;
    checkOutput("rstMid.serial", 32'(serialS[0]), 32'd0);
    checkOutput("rstMid.busy", 32'(busyS[0]), 32'd0);
    checkOutput("rstMid.ready", 32'(readyS[0]), 32'd1);
    checkOutput("rstMid.done", 32'(doneS[0]), 32'd0);
    tick();
    clear_n = 1'b1;
    doneCount = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      doneCount += int'(doneS[0]);
    end
    checkOutput("rstMid.noDone", 32'(doneCount), 32'd0);

    applyStimulus(0, 1'b1, 32'h3, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      loadS[0] = 1'b0;
      checkOutput($sformatf("after.bit%0d", k), 32'(serialS[0]), 32'(seqAfter[k]));
    end
    checkOutput("after.done", 32'(doneS[0]), 32'd1);
    applyStimulus(0, 1'b0, '0, 1'b0);
    tick();

    // Randomised traffic on both configurations, with one stray reset pulse
    for (int n = 0; n < 1500; n++) begin
      for (int g = 0; g < 2; g++) begin
        applyStimulus(g, ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 2) != 0));
      end
      if (n == 700) begin
        #2 clear_n = 1'b0;
        #2 clear_n = 1'b1;
      end
      tick();
    end

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_shift_param.md
# piso_shift_param

Parametrised parallel-in/serial-out shifter, the successor to the fixed 4-bit PISO used on the LED demo path. It adds the following over the fixed version:
- configurable word width and bit order
- a load/ready handshake
- a clock-enable (Shift_En) that paces the output bit rate
- a selectable idle line level
- a one-cycle Done pulse per frame

It sits between a parallel word source (switches, counter, register) and a single serial output pin or LED.

## Interface

- WIDTH, 4: bits per frame; legal range 2..32.
- MSB_FIRST, 1: 1 = Parallel_In[WIDTH-1] is sent first; 0 = Parallel_In[0] is sent first.
- IDLE_LEVEL, 0: value of Serial_Out when no frame is in flight.

- clk  input  1  rising-edge clock, single clock domain.
- clear_n  input  1  asynchronous, active-low reset.
- load  input  1  load request; sampled only while Ready=1.
- Parallel_In  input  WIDTH  word captured on an accepted load.
- Shift_En  input  1  bit-advance enable; ignored in IDLE.
- Ready  output  1  registered; 1 = block can accept a load this cycle.
- Busy  output  1  registered; 1 = frame in flight.
- Serial_Out  output  1  registered serial data.
- Done  output  1  registered one-cycle pulse after the last bit of a frame.

## Operation

- State machine has two states, IDLE and SHIFT. A bit counter cnt spans 0..WIDTH-1, sized $clog2(WIDTH). A WIDTH-bit shift register sreg holds the frame.
- Reset (clear_n=0, asynchronous):
  - state=IDLE, cnt=0, sreg=0.
  - Ready=1, Busy=0, Done=0, Serial_Out=IDLE_LEVEL.
  - Any frame in flight is discarded with no Done pulse.
- IDLE: Ready=1, Busy=0, Serial_Out=IDLE_LEVEL. Shift_En has no effect.
- IDLE with load=1 at a clock edge:
  - capture Parallel_In into sreg and set cnt=0.
  - Serial_Out = first bit, chosen per MSB_FIRST.
  - go to SHIFT; Ready=0, Busy=1.
- SHIFT with Shift_En=0: everything holds. The current bit stays on Serial_Out indefinitely.
- SHIFT with Shift_En=1 and cnt<WIDTH-1: shift sreg one position toward the output end, cnt+1, Serial_Out = next bit.
- SHIFT with Shift_En=1 and cnt==WIDTH-1:
  - go to IDLE; Serial_Out=IDLE_LEVEL.
  - Done=1 for exactly one cycle; Ready=1, Busy=0.
- load while in SHIFT is ignored. Parallel_In changes during SHIFT do not affect the frame in flight.
- Ready and Busy are always complementary.
- Serial_Out is glitch-free: it comes straight from a flop, with no combinational path from any input.

## Timing

- Load-to-first-bit latency: Serial_Out shows the first bit in the cycle right after the accepting edge.
- With Shift_En held at 1, each bit occupies exactly one cycle.
  - Done is high in cycle WIDTH+1 counted from the accepting edge, coincident with Ready returning to 1.
- Minimum frame period is WIDTH+1 cycles:
  - Ready is registered, so there is one idle-level cycle between back-to-back frames.
  - load may be held high continuously.
- With Shift_En pulsed every N cycles, each bit lasts from one Shift_En sample to the next. The first bit lasts from the load edge to the first Shift_En=1 edge.
- Reset deassertion needs no synchronisation inside the block. The first load is accepted on the first edge with clear_n=1.

## Test plan

- Reset values: drive clear_n=0, then release with WIDTH=4 and IDLE_LEVEL=0 -> Ready=1, Busy=0, Done=0, Serial_Out=0. Toggling Shift_En produces no change.
- MSB-first frame: WIDTH=4, MSB_FIRST=1, Shift_En=1, load 4'b0101 -> Serial_Out 0,1,0,1 on consecutive cycles, then 0. Done pulses once in cycle 5 and Busy is high for 4 cycles.
- LSB-first frame and idle level: WIDTH=8, MSB_FIRST=0, IDLE_LEVEL=1, load 8'hC8 -> Serial_Out 0,0,0,1,0,0,1,1, then returns to 1.
- Back-to-back frames: WIDTH=4, load held high, Parallel_In=4'h8 then 4'hC -> Serial_Out 1,0,0,0,idle,1,1,0,0. Exactly one Done pulse per frame; a load asserted mid-frame is ignored.
- Paced shifting: Shift_En high 1 cycle in every 3, load 4'hA -> each bit held 3 cycles (first bit from the load edge to the first enable). Done arrives after the 4th enable.
- Reset mid-frame: assert clear_n=0 during bit 2 of 4'hF -> outputs go to reset values immediately without waiting for a clock edge, and no Done pulse occurs. The next load of 4'h3 sends 0,0,1,1.
